// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-port arbiter: requester ids, FSM states, tag width.
package dmem_arb_pkg;

    localparam int unsigned TAG_W = 1;

    typedef enum logic [TAG_W-1:0] {
        OWN_R0 = 1'b0,
        OWN_R1 = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // The requester that is not o; used to rotate priority after a grant.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_R0) ? OWN_R1 : OWN_R0;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundles for the data-port arbiter: one requester port and the RAM port-1 side.

// Requester command/response bundle. master = requester, slave = arbiter.
interface dmem_req_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 32
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic [DW/8-1:0]   mask;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_data;

    modport master (
        output valid, we, addr, data, mask,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, we, addr, data, mask,
        output ready, rsp_valid, rsp_data
    );
endinterface

// RAM data-port bundle. master = arbiter issuing commands, slave = RAM.
interface dmem_ram_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 32
);
    logic              t_valid;
    logic              t_ready;
    logic              t_we;
    logic [AW-1:0]     t_addr;
    logic [DW-1:0]     t_data;
    logic [DW/8-1:0]   t_mask;
    logic              i_valid;
    logic [DW-1:0]     i_data;
    logic              i_ready;

    modport master (
        output t_valid, t_we, t_addr, t_data, t_mask, i_ready,
        input  t_ready, i_valid, i_data
    );

    modport slave (
        input  t_valid, t_we, t_addr, t_data, t_mask, i_ready,
        output t_ready, i_valid, i_data
    );
endinterface

// File: rtl/dmem_arb_tag_fifo.sv
// In-order FIFO of read owners; head names the requester of the oldest read in flight.
module dmem_arb_tag_fifo
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstf,
    input  logic          push,
    input  logic          pop,
    input  owner_e        din,
    output owner_e        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Wrap explicitly so any depth works, not only powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Tag storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the RAM data port with in-order read-response routing.
// Optional build macro DMEM_ARB_RR_EN: round-robin priority; otherwise r0 has fixed priority.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW              = 15,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rstf,
    dmem_req_if.slave  r0,
    dmem_req_if.slave  r1,
    dmem_ram_if.master ram,
    output logic       err_orphan
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    state_e          state, state_n;
    owner_e          owner, owner_n;
`ifdef DMEM_ARB_RR_EN
    owner_e          prio, prio_n;
`endif
    owner_e          sel;
    logic            sel_vld;
    logic            sel_r1;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [DW/8-1:0] sel_mask;
    logic            accept;
    logic            r0_elig;
    logic            r1_elig;

    logic            fifo_push;
    logic            fifo_pop;
    owner_e          fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Reads are held off on the registered occupancy only; writes never need a tag.
    assign r0_elig = r0.valid & (r0.we | ~fifo_full);
    assign r1_elig = r1.valid & (r1.we | ~fifo_full);

    // Grant selection and FSM next state; HOLD pins the grant to the stalled owner.
    always_comb begin
        state_n = state;
        owner_n = owner;
`ifdef DMEM_ARB_RR_EN
        prio_n  = prio;
`endif
        sel     = OWN_R0;
        sel_vld = 1'b0;
        unique case (state)
            ST_IDLE: begin
`ifdef DMEM_ARB_RR_EN
                if (prio == OWN_R0) begin
                    if (r0_elig) begin
                        sel_vld = 1'b1;
                        sel     = OWN_R0;
                    end else if (r1_elig) begin
                        sel_vld = 1'b1;
                        sel     = OWN_R1;
                    end
                end else begin
                    if (r1_elig) begin
                        sel_vld = 1'b1;
                        sel     = OWN_R1;
                    end else if (r0_elig) begin
                        sel_vld = 1'b1;
                        sel     = OWN_R0;
                    end
                end
`else
                if (r0_elig) begin
                    sel_vld = 1'b1;
                    sel     = OWN_R0;
                end else if (r1_elig) begin
                    sel_vld = 1'b1;
                    sel     = OWN_R1;
                end
`endif
                if (sel_vld) begin
                    if (ram.t_ready) begin
`ifdef DMEM_ARB_RR_EN
                        prio_n = other_owner(sel);
`endif
                    end else begin
                        state_n = ST_HOLD;
                        owner_n = sel;
                    end
                end
            end
            ST_HOLD: begin
                sel     = owner;
                sel_vld = (owner == OWN_R1) ? r1.valid : r0.valid;
                if (sel_vld && ram.t_ready) begin
                    state_n = ST_IDLE;
`ifdef DMEM_ARB_RR_EN
                    prio_n  = other_owner(owner);
`endif
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM, owner and priority registers.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state <= ST_IDLE;
            owner <= OWN_R0;
`ifdef DMEM_ARB_RR_EN
            prio  <= OWN_R0;
`endif
        end else begin
            state <= state_n;
            owner <= owner_n;
`ifdef DMEM_ARB_RR_EN
            prio  <= prio_n;
`endif
        end
    end

    // Command mux onto the RAM port; ready is a pass-through of t_ready to the granted requester.
    assign sel_r1      = (sel == OWN_R1);
    assign sel_we      = sel_r1 ? r1.we   : r0.we;
    assign sel_addr    = sel_r1 ? r1.addr : r0.addr;
    assign sel_data    = sel_r1 ? r1.data : r0.data;
    assign sel_mask    = sel_r1 ? r1.mask : r0.mask;
    assign accept      = sel_vld & ram.t_ready;

    assign ram.t_valid = sel_vld;
    assign ram.t_we    = sel_we;
    assign ram.t_addr  = sel_addr;
    assign ram.t_data  = sel_data;
    assign ram.t_mask  = sel_mask;
    assign ram.i_ready = 1'b1;
    assign r0.ready    = accept & ~sel_r1;
    assign r1.ready    = accept & sel_r1;

    // Owner tags for accepted reads; each RAM response retires the oldest tag.
    assign fifo_push = accept & ~sel_we;
    assign fifo_pop  = ram.i_valid & ~fifo_empty;

    dmem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rstf  (rstf),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sel),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Response routing to the requester named by the FIFO head.
    assign r0.rsp_valid = fifo_pop & (fifo_head == OWN_R0);
    assign r1.rsp_valid = fifo_pop & (fifo_head == OWN_R1);
    assign r0.rsp_data  = ram.i_data;
    assign r1.rsp_data  = ram.i_data;

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            err_orphan <= 1'b0;
        end else if (ram.i_valid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rstf)
        fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, checked against a queue model.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 32;
    localparam int          MAXO = 4;

    logic clk = 1'b0;
    logic rstf;
    logic err_orphan;

    always #5 clk = ~clk;

    dmem_req_if #(.AW(AW), .DW(DW)) r0_if ();
    dmem_req_if #(.AW(AW), .DW(DW)) r1_if ();
    dmem_ram_if #(.AW(AW), .DW(DW)) ram_if ();

    dmem_port_arbiter #(
        .AW              (AW),
        .DW              (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk        (clk),
        .rstf       (rstf),
        .r0         (r0_if),
        .r1         (r1_if),
        .ram        (ram_if),
        .err_orphan (err_orphan)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int              q[$];      // owners of reads in flight, oldest first
    int              lock;      // requester whose presented command is stalled, -1 if none
    bit              m_err;
    bit              acc[2];
`ifdef DMEM_ARB_RR_EN
    int              rr;        // requester favoured at the next free grant
`endif
    int              sel;
    bit              el[2];
    bit              rv[2];
    bit              rwe[2];
    logic [AW-1:0]   raddr[2];
    logic [DW-1:0]   rdata[2];
    logic [DW/8-1:0] rmask[2];
    bit              e_tv;
    bit              e_rv[2];

    always @(negedge clk) begin
        if (!rstf) begin
            q.delete();
            lock   = -1;
            m_err  = 1'b0;
            acc[0] = 1'b0;
            acc[1] = 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr     = 0;
`endif
        end else begin
            rv[0] = r0_if.valid;  rwe[0] = r0_if.we;  raddr[0] = r0_if.addr;
            rdata[0] = r0_if.data; rmask[0] = r0_if.mask;
            rv[1] = r1_if.valid;  rwe[1] = r1_if.we;  raddr[1] = r1_if.addr;
            rdata[1] = r1_if.data; rmask[1] = r1_if.mask;

            sel = -1;
            if (lock >= 0) begin
                if (rv[lock]) sel = lock;
            end else begin
                for (int i = 0; i < 2; i++) el[i] = rv[i] && (rwe[i] || q.size() < MAXO);
`ifdef DMEM_ARB_RR_EN
                if (el[rr]) sel = rr;
                else if (el[1-rr]) sel = 1 - rr;
`else
                if (el[0]) sel = 0;
                else if (el[1]) sel = 1;
`endif
            end
            e_tv = (sel >= 0);

            chk("t_valid", 64'(ram_if.t_valid), 64'(e_tv));
            chk("r0_ready", 64'(r0_if.ready), 64'(e_tv && sel == 0 && ram_if.t_ready));
            chk("r1_ready", 64'(r1_if.ready), 64'(e_tv && sel == 1 && ram_if.t_ready));
            if (e_tv) begin
                chk("t_we",   64'(ram_if.t_we),   64'(rwe[sel]));
                chk("t_addr", 64'(ram_if.t_addr), 64'(raddr[sel]));
                chk("t_data", 64'(ram_if.t_data), 64'(rdata[sel]));
                chk("t_mask", 64'(ram_if.t_mask), 64'(rmask[sel]));
            end

            e_rv[0] = 1'b0;
            e_rv[1] = 1'b0;
            if (ram_if.i_valid && q.size() > 0) e_rv[q[0]] = 1'b1;
            chk("r0_rsp_valid", 64'(r0_if.rsp_valid), 64'(e_rv[0]));
            chk("r1_rsp_valid", 64'(r1_if.rsp_valid), 64'(e_rv[1]));
            if (e_rv[0]) chk("r0_rsp_data", 64'(r0_if.rsp_data), 64'(ram_if.i_data));
            if (e_rv[1]) chk("r1_rsp_data", 64'(r1_if.rsp_data), 64'(ram_if.i_data));
            chk("i_ready", 64'(ram_if.i_ready), 64'(1));
            chk("err_orphan", 64'(err_orphan), 64'(m_err));

            if (ram_if.i_valid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1'b1;
            end
            acc[0] = e_tv && sel == 0 && ram_if.t_ready;
            acc[1] = e_tv && sel == 1 && ram_if.t_ready;
            if (e_tv) begin
                if (ram_if.t_ready) begin
                    if (!rwe[sel]) q.push_back(sel);
                    lock = -1;
`ifdef DMEM_ARB_RR_EN
                    rr   = 1 - sel;
`endif
                end else begin
                    lock = sel;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        if (i == 0) begin
            r0_if.valid = v; r0_if.we = we; r0_if.addr = a; r0_if.data = d; r0_if.mask = m;
        end else begin
            r1_if.valid = v; r1_if.we = we; r1_if.addr = a; r1_if.data = d; r1_if.mask = m;
        end
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                AW'($urandom), DW'($urandom), (DW/8)'($urandom));
    endtask

    bit cur_v;

    initial begin
        rstf = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        ram_if.t_ready = 1'b0;
        ram_if.i_valid = 1'b0;
        ram_if.i_data  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_t_valid",  64'(ram_if.t_valid),   64'(0));
        chk("rst_r0_ready", 64'(r0_if.ready),      64'(0));
        chk("rst_r1_ready", 64'(r1_if.ready),      64'(0));
        chk("rst_r0_rsp",   64'(r0_if.rsp_valid),  64'(0));
        chk("rst_r1_rsp",   64'(r1_if.rsp_valid),  64'(0));
        chk("rst_i_ready",  64'(ram_if.i_ready),   64'(1));
        chk("rst_err",      64'(err_orphan),       64'(0));

        // Single read from r0, response two cycles after acceptance
        tick();
        rstf = 1'b1;
        set_req(0, 1'b1, 1'b0, AW'(16'h0010), '0, 4'hF);
        ram_if.t_ready = 1'b1;
        @(negedge clk);
        chk("rd_t_valid",  64'(ram_if.t_valid), 64'(1));
        chk("rd_t_addr",   64'(ram_if.t_addr),  64'(16'h0010));
        chk("rd_r0_ready", 64'(r0_if.ready),    64'(1));
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        ram_if.i_valid = 1'b1;
        ram_if.i_data  = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_r0_rsp",      64'(r0_if.rsp_valid), 64'(1));
        chk("rd_r0_rsp_data", 64'(r0_if.rsp_data),  64'(32'hDEADBEEF));
        chk("rd_r1_rsp",      64'(r1_if.rsp_valid), 64'(0));
        tick();
        ram_if.i_valid = 1'b0;
        @(negedge clk);
        chk("rd_r0_rsp_pulse", 64'(r0_if.rsp_valid), 64'(0));

        // r1 write stalled 3 cycles; r0 arriving meanwhile must wait
        tick();
        ram_if.t_ready = 1'b0;
        set_req(1, 1'b1, 1'b1, AW'(16'h0020), 32'h1234, 4'hF);
        @(negedge clk);
        chk("hold_c1_addr", 64'(ram_if.t_addr), 64'(16'h0020));
        tick();
        set_req(0, 1'b1, 1'b0, AW'(16'h0030), '0, 4'hF);
        @(negedge clk);
        chk("hold_c2_addr",     64'(ram_if.t_addr), 64'(16'h0020));
        chk("hold_c2_r0_ready", 64'(r0_if.ready),   64'(0));
        tick();
        @(negedge clk);
        chk("hold_c3_addr", 64'(ram_if.t_addr), 64'(16'h0020));
        tick();
        ram_if.t_ready = 1'b1;
        @(negedge clk);
        chk("hold_c4_r1_ready", 64'(r1_if.ready),   64'(1));
        chk("hold_c4_addr",     64'(ram_if.t_addr), 64'(16'h0020));
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("hold_c5_r0_ready", 64'(r0_if.ready),   64'(1));
        chk("hold_c5_addr",     64'(ram_if.t_addr), 64'(16'h0030));
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        ram_if.i_valid = 1'b1;
        ram_if.i_data  = 32'h0BADF00D;
        @(negedge clk);
        chk("hold_r0_rsp", 64'(r0_if.rsp_valid), 64'(1));
        tick();
        ram_if.i_valid = 1'b0;

        // Fill the tag FIFO; reads block, writes still pass, a pop unblocks one cycle later
        for (int k = 0; k < MAXO; k++) begin
            set_req(0, 1'b1, 1'b0, AW'(16'h0100 + 4 * k), '0, 4'hF);
            @(negedge clk);
            chk("fill_r0_ready", 64'(r0_if.ready), 64'(1));
            tick();
        end
        set_req(0, 1'b1, 1'b0, AW'(16'h0200), '0, 4'hF);
        @(negedge clk);
        chk("full_r0_ready", 64'(r0_if.ready),    64'(0));
        chk("full_t_valid",  64'(ram_if.t_valid), 64'(0));
        tick();
        set_req(1, 1'b1, 1'b1, AW'(16'h0300), 32'h5555AAAA, 4'h3);
        @(negedge clk);
        chk("full_r1_wr_ready", 64'(r1_if.ready), 64'(1));
        chk("full_r0_still_0",  64'(r0_if.ready), 64'(0));
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        ram_if.i_valid = 1'b1;
        ram_if.i_data  = 32'h11111111;
        @(negedge clk);
        chk("pop_same_cycle_r0_ready", 64'(r0_if.ready),     64'(0));
        chk("pop_r0_rsp",              64'(r0_if.rsp_valid), 64'(1));
        tick();
        ram_if.i_valid = 1'b0;
        @(negedge clk);
        chk("pop_next_cycle_r0_ready", 64'(r0_if.ready), 64'(1));
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < MAXO; k++) begin
            ram_if.i_valid = 1'b1;
            ram_if.i_data  = DW'($urandom);
            tick();
        end
        ram_if.i_valid = 1'b0;

        // Orphan response: dropped, sticky error until reset
        tick();
        ram_if.i_valid = 1'b1;
        ram_if.i_data  = 32'hCAFEF00D;
        @(negedge clk);
        chk("orph_r0_rsp", 64'(r0_if.rsp_valid), 64'(0));
        chk("orph_r1_rsp", 64'(r1_if.rsp_valid), 64'(0));
        tick();
        ram_if.i_valid = 1'b0;
        @(negedge clk);
        chk("orph_err_set", 64'(err_orphan), 64'(1));
        repeat (3) tick();
        @(negedge clk);
        chk("orph_err_sticky", 64'(err_orphan), 64'(1));
        tick();
        rstf = 1'b0;
        #2;
        chk("orph_err_cleared", 64'(err_orphan), 64'(0));
        tick();
        rstf = 1'b1;

        // Both requesters continuously valid (writes)
        set_req(0, 1'b1, 1'b1, AW'(16'h0400), 32'hA0A0A0A0, 4'hF);
        set_req(1, 1'b1, 1'b1, AW'(16'h0500), 32'hB1B1B1B1, 4'hF);
        ram_if.t_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
`ifdef DMEM_ARB_RR_EN
            chk("rr_r0_ready", 64'(r0_if.ready), 64'(c % 2 == 0));
            chk("rr_r1_ready", 64'(r1_if.ready), 64'(c % 2 == 1));
`else
            chk("fix_r0_ready", 64'(r0_if.ready), 64'(1));
            chk("fix_r1_ready", 64'(r1_if.ready), 64'(0));
`endif
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("r1_after_r0_drop", 64'(r1_if.ready), 64'(1));
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);

        // Random traffic with a mid-run reset
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (c == 2000) begin
                rstf = 1'b0;
                set_req(0, 1'b0, 1'b0, '0, '0, '0);
                set_req(1, 1'b0, 1'b0, '0, '0, '0);
                ram_if.i_valid = 1'b0;
            end else if (c == 2002) begin
                rstf = 1'b1;
            end
            if (rstf) begin
                cur_v = r0_if.valid;
                if (!(cur_v && !acc[0])) rand_req(0);
                cur_v = r1_if.valid;
                if (!(cur_v && !acc[1])) rand_req(1);
                ram_if.t_ready = 1'($urandom_range(0, 3) != 0);
                if (q.size() > 0) ram_if.i_valid = 1'($urandom_range(0, 2) == 0);
                else              ram_if.i_valid = 1'($urandom_range(0, 39) == 0);
                ram_if.i_data = DW'($urandom);
            end
        end
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        ram_if.i_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
